// File: rtl/result_dump_reader.sv
// result_dump_reader: after the processor signals done, walks data memory
// through the readback port and streams each word out on a valid/ready
// interface, flagging the final word and pulsing dump_done at completion.
//
// Output handshake: a word transfers when out_valid and out_ready are both
// high at a rising clk edge; once out_valid is raised, out_data and out_last
// stay stable until that transfer, with no timeout.
module result_dump_reader #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              WORD_COUNT = 10,
  parameter int              RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              dump_done
);

  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((WORD_COUNT > 0) ? WORD_COUNT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic             EMPTY    = (WORD_COUNT == 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done_prev;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_dump_done;
  logic              w_trigger;
  logic              w_capture;

  assign mem_addr  = r_mem_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign dump_done = r_dump_done;

  // Next-state decode: rising done starts a dump, read latency gates capture.
  always_comb begin
    w_state_nxt = r_state;
    w_trigger   = done_in & ~r_done_prev;
    w_capture   = (r_cnt == CNT_LAST);
    case (r_state)
      IDLE: begin
        if (w_trigger) w_state_nxt = EMPTY ? FINISH : WAIT;
      end
      WAIT: begin
        if (w_capture) w_state_nxt = PRESENT;
      end
      PRESENT: begin
        if (out_ready) w_state_nxt = r_out_last ? FINISH : WAIT;
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: address walk, latency counter, captured word and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_done_prev <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_dump_done <= 1'b0;
    end else begin
      r_done_prev <= done_in;
      r_busy      <= (w_state_nxt != IDLE);
      r_dump_done <= (w_state_nxt == FINISH);
      case (r_state)
        IDLE: begin
          if (w_trigger && !EMPTY) begin
            r_idx      <= '0;
            r_mem_addr <= BASE_ADDR;
            r_cnt      <= '0;
          end
        end
        WAIT: begin
          if (w_capture) begin
            r_out_data  <= mem_rdata;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_idx == LAST_IDX);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (!r_out_last) begin
              r_idx      <= r_idx + 1'b1;
              r_mem_addr <= r_mem_addr + 1'b1;
              r_cnt      <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_dump_reader.sv
// Directed bench for result_dump_reader: main 10-word dump with backpressure,
// level/retrigger behaviour and async reset, plus three parameter corners.
module tb_result_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Main instance: BASE 0, 10 words, RD_LAT 1, combinational memory model.
  logic        m_done, m_ready, m_valid, m_last, m_busy, m_dd;
  logic [31:0] m_addr, m_rdata, m_data;
  logic [31:0] m_mem [16];
  assign m_rdata = m_mem[m_addr[3:0]];

  result_dump_reader u_main (
    .clk(clk), .rst(rst), .done_in(m_done), .mem_addr(m_addr), .mem_rdata(m_rdata),
    .out_data(m_data), .out_valid(m_valid), .out_ready(m_ready), .out_last(m_last),
    .busy(m_busy), .dump_done(m_dd)
  );

  // Empty dump instance.
  logic        z_done, z_valid, z_last, z_busy, z_dd;
  logic [31:0] z_addr, z_data;

  result_dump_reader #(.WORD_COUNT(0)) u_empty (
    .clk(clk), .rst(rst), .done_in(z_done), .mem_addr(z_addr), .mem_rdata(32'h0),
    .out_data(z_data), .out_valid(z_valid), .out_ready(1'b1), .out_last(z_last),
    .busy(z_busy), .dump_done(z_dd)
  );

  // RD_LAT=3 instance with a memory whose data is valid 3 edges after address.
  logic        t_done, t_ready, t_valid, t_last, t_busy, t_dd;
  logic [31:0] t_addr, t_data, t_d1, t_d2;
  logic [31:0] t_mem [16];
  always @(posedge clk) begin
    t_d1 <= t_mem[t_addr[3:0]];
    t_d2 <= t_d1;
  end

  result_dump_reader #(.BASE_ADDR(32'd5), .WORD_COUNT(3), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .done_in(t_done), .mem_addr(t_addr), .mem_rdata(t_d2),
    .out_data(t_data), .out_valid(t_valid), .out_ready(t_ready), .out_last(t_last),
    .busy(t_busy), .dump_done(t_dd)
  );

  // Address wrap instance: 4-bit address starting at 14.
  logic       w_done, w_ready, w_valid, w_last, w_busy, w_dd;
  logic [3:0] w_addr;
  logic [7:0] w_data, w_rdata;
  logic [7:0] w_mem [16];
  assign w_rdata = w_mem[w_addr];

  result_dump_reader #(.ADDR_W(4), .DATA_W(8), .BASE_ADDR(4'd14), .WORD_COUNT(4)) u_wrap (
    .clk(clk), .rst(rst), .done_in(w_done), .mem_addr(w_addr), .mem_rdata(w_rdata),
    .out_data(w_data), .out_valid(w_valid), .out_ready(w_ready), .out_last(w_last),
    .busy(w_busy), .dump_done(w_dd)
  );

  logic [31:0] sorted_v [10] = '{32'd2, 32'd3, 32'd5, 32'd9, 32'd10,
                                 32'd19, 32'd19, 32'd43, 32'd61, 32'd86};
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collects n_words of the main dump, optionally stalling one word.
  task automatic run_dump(input int n_words, input int stall_idx, input int stall_cyc);
    logic [31:0] expv;
    int cnt;
    exp_q = {};
    for (int k = 0; k < 10; k++) exp_q.push_back(sorted_v[k]);
    m_ready = 1'b1;
    for (int i = 0; i < n_words; i++) begin
      cnt = 0;
      while (m_valid !== 1'b1 && cnt < 20) begin
        tick();
        cnt++;
      end
      if (i > 0) chk("word_gap", 32'(cnt), 32'd1);
      expv = exp_q.pop_front();
      chk("word_valid", 32'(m_valid), 32'd1);
      chk("word_data", m_data, expv);
      chk("word_last", 32'(m_last), 32'(i == 9));
      chk("word_addr", m_addr, 32'(i));
      if (i == stall_idx) begin
        m_ready = 1'b0;
        for (int s = 0; s < stall_cyc; s++) begin
          tick();
          chk("stall_valid", 32'(m_valid), 32'd1);
          chk("stall_data", m_data, expv);
          chk("stall_addr", m_addr, 32'(i));
        end
        m_ready = 1'b1;
      end
      tick();
      chk("post_hs_valid", 32'(m_valid), 32'd0);
      chk("post_hs_done", 32'(m_dd), 32'(i == 9));
    end
    if (n_words == 10) begin
      chk("finish_busy", 32'(m_busy), 32'd1);
      tick();
      chk("done_pulse_end", 32'(m_dd), 32'd0);
      chk("idle_busy", 32'(m_busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [3:0] wa;
    for (int k = 0; k < 16; k++) begin
      m_mem[k] = (k < 10) ? sorted_v[k] : 32'hDEAD0000 + 32'(k);
      t_mem[k] = 32'h100 + 32'(k);
      w_mem[k] = 8'hA0 + 8'(k);
    end
    rst = 1'b1;
    m_done = 0; m_ready = 0; z_done = 0; t_done = 0; t_ready = 0; w_done = 0; w_ready = 0;
    #2;
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_done", 32'(m_dd), 32'd0);
    chk("rst_wrap_addr", 32'(w_addr), 32'd14);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    chk("idle_busy0", 32'(m_busy), 32'd0);

    // Post-sort readback with backpressure on word 3.
    m_done = 1'b1;
    m_ready = 1'b1;
    tick();
    chk("e0_busy", 32'(m_busy), 32'd1);
    chk("e0_valid", 32'(m_valid), 32'd0);
    chk("e0_addr", m_addr, 32'd0);
    tick();
    chk("first_valid", 32'(m_valid), 32'd1);
    chk("first_data", m_data, 32'd2);
    run_dump(10, 3, 5);

    // Level-held done must not retrigger.
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("level_no_valid", 32'(m_valid), 32'd0);
      chk("level_no_busy", 32'(m_busy), 32'd0);
    end

    // Drop and raise: a second identical dump.
    m_done = 1'b0;
    tick();
    m_done = 1'b1;
    run_dump(10, -1, 0);

    // Reset during word 5, done_in still high afterwards.
    m_done = 1'b0;
    tick();
    m_done = 1'b1;
    run_dump(5, -1, 0);
    m_ready = 1'b0;
    tick();
    chk("w5_valid", 32'(m_valid), 32'd1);
    chk("w5_data", m_data, 32'd19);
    chk("w5_addr", m_addr, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_addr", m_addr, 32'd0);
    chk("arst_data", m_data, 32'd0);
    chk("arst_busy", 32'(m_busy), 32'd0);
    chk("arst_last", 32'(m_last), 32'd0);
    chk("arst_done", 32'(m_dd), 32'd0);
    tick();
    chk("arst_hold_done", 32'(m_dd), 32'd0);
    #2 rst = 1'b0;
    run_dump(10, -1, 0);

    // WORD_COUNT=0: done pulse without any word.
    z_done = 1'b1;
    tick();
    chk("empty_done", 32'(z_dd), 32'd1);
    chk("empty_busy", 32'(z_busy), 32'd1);
    chk("empty_valid", 32'(z_valid), 32'd0);
    tick();
    chk("empty_done_end", 32'(z_dd), 32'd0);
    chk("empty_idle", 32'(z_busy), 32'd0);
    chk("empty_valid2", 32'(z_valid), 32'd0);
    tick();
    chk("empty_no_retrig", 32'(z_dd), 32'd0);

    // RD_LAT=3: first word at E0+3, each word from its own address.
    t_ready = 1'b1;
    t_done = 1'b1;
    tick();
    chk("lat3_e0", 32'(t_valid), 32'd0);
    tick();
    chk("lat3_e1", 32'(t_valid), 32'd0);
    tick();
    chk("lat3_e2", 32'(t_valid), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        cnt = 0;
        while (t_valid !== 1'b1 && cnt < 20) begin
          tick();
          cnt++;
        end
        chk("lat3_gap", 32'(cnt), 32'd3);
      end
      chk("lat3_valid", 32'(t_valid), 32'd1);
      chk("lat3_addr", t_addr, 32'd5 + 32'(i));
      chk("lat3_data", t_data, 32'h105 + 32'(i));
      chk("lat3_last", 32'(t_last), 32'(i == 2));
      tick();
    end
    chk("lat3_done", 32'(t_dd), 32'd1);

    // Address wrap: 14, 15, 0, 1.
    w_ready = 1'b1;
    w_done = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      while (w_valid !== 1'b1 && cnt < 20) begin
        tick();
        cnt++;
      end
      wa = 4'(14 + i);
      chk("wrap_valid", 32'(w_valid), 32'd1);
      chk("wrap_addr", 32'(w_addr), 32'(wa));
      chk("wrap_data", 32'(w_data), 32'h0A0 + 32'(wa));
      chk("wrap_last", 32'(w_last), 32'(i == 3));
      tick();
    end
    chk("wrap_done", 32'(w_dd), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_dump_reader.md
Name: result_dump_reader

Overview:
- Read-side counterpart of the memory-load path used to initialise processor_top.
- After the processor raises done, it walks the data memory through the mem_addr/processor_out readback port, one word at a time.
- Each word is presented on a valid/ready output stream, with a last-word flag and a completion pulse.
- It replaces hand-sequenced readback and feeds a host/UART/log sink.

Parameters:
- ADDR_W, 32, width of mem_addr.
- DATA_W, 32, width of memory words / processor_out.
- BASE_ADDR, 0, first data-memory address dumped.
- WORD_COUNT, 10, number of consecutive words dumped (0 legal).
- RD_LAT, 1, cycles from mem_addr change to valid processor_out (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- done_in  in  1  processor_top done flag (level).
- mem_addr  out  ADDR_W  data-memory readback address to processor_top.
- mem_rdata  in  DATA_W  processor_top processor_out.
- out_data  out  DATA_W  dumped word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts word when out_valid & out_ready at a rising edge.
- out_last  out  1  high with the final word (idx == WORD_COUNT-1).
- busy  out  1  high in any state except IDLE.
- dump_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async, rst=1), all outputs and state forced immediately:
  - state=IDLE, idx=0, wait counter=0, done_prev=0.
  - mem_addr=BASE_ADDR, out_data=0, out_valid=0, out_last=0, busy=0, dump_done=0.
- Trigger: done_prev <= done_in every cycle. A dump starts only on done_in & ~done_prev sampled in IDLE.
  - done_in already high when reset releases therefore triggers one dump.
  - done_in held high after a dump does not retrigger.
  - Edges arriving outside IDLE are lost.
- IDLE: out_valid=0, busy=0. On trigger at edge E0:
  - If WORD_COUNT==0, go to FINISH.
  - Otherwise go to WAIT with idx=0, mem_addr=BASE_ADDR, wait counter=0.
- WAIT: counter increments each edge. At the RD_LAT-th edge after mem_addr was updated:
  - out_data <= mem_rdata, out_valid <= 1.
  - out_last <= (idx==WORD_COUNT-1).
  - state -> PRESENT.
  - First word is valid after edge E0+RD_LAT.
- PRESENT: out_data, out_valid and out_last are held stable while out_ready=0, with no timeout. On an edge with out_ready=1:
  - If out_last: out_valid <= 0, out_last <= 0, state -> FINISH.
  - Else: idx <= idx+1, mem_addr <= mem_addr+1, out_valid <= 0, state -> WAIT, counter=0.
- Throughput is RD_LAT+1 cycles per word with out_ready tied high.
- FINISH: dump_done=1 for exactly one cycle, busy=1, then IDLE.
- Addresses: mem_addr = BASE_ADDR + idx, modulo 2^ADDR_W (wraps silently).
- Registers: out_data updates only at the capture edge in WAIT. All outputs are registered.
- done_in falling mid-dump: ignored; the dump runs to completion.
- Reset mid-dump: dump aborted, no dump_done. If done_in is still high after release, a fresh full dump starts from BASE_ADDR.
- out_ready high in IDLE/WAIT/FINISH has no effect.

Test Plan:
- Post-sort readback: model memory [0..9] = 2,3,5,9,10,19,19,43,61,86 with RD_LAT=1; raise done_in, out_ready=1.
  - Required: 10 handshakes in that order.
  - out_last only on 86.
  - mem_addr steps 0..9.
  - dump_done pulses once, one cycle after the 86 handshake.
  - First out_valid is 1 cycle after the trigger edge.
- Backpressure: out_ready=0 for 5 cycles at word 3 (value 9).
  - Required: out_data=9 and out_valid=1 held constant, mem_addr stays 3, no word skipped or duplicated.
- Level done / retrigger:
  - Required: done_in held high after completion causes no second dump.
  - Drop then raise done_in: a second identical 10-word dump.
- Reset mid-dump: assert rst asynchronously (between clock edges) during word 5.
  - Required: outputs go to reset values immediately, no dump_done.
  - With done_in high, after release a full dump restarts at address 0.
- Parameter corners:
  - WORD_COUNT=0: a done_in rise gives a dump_done pulse with no out_valid.
  - RD_LAT=3: first out_valid at E0+3; each word captures the value at its own address.
  - BASE_ADDR=2^ADDR_W-2, WORD_COUNT=4: mem_addr sequence wraps to 0,1.
